// File: rtl/pep_ks_common_param_pkg.sv
// Shared key-switch parameters and the types used by the command scheduler.
//   KS_CMD_W      : width of one key-switch command word
//   sched_error_t : error pulse vector, bit 0 credit_ovf, bit 1 done_udf,
//                   bit 2 flush_push
//   sched_state_e : scheduler run / flush state
package pep_ks_common_param_pkg;

    localparam int KS_CMD_W = 8;

    // Packed MSB-first so that the [0] bit of the vector is credit_ovf.
    typedef struct packed {
        logic flush_push;
        logic done_udf;
        logic credit_ovf;
    } sched_error_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } sched_state_e;

endpackage

// File: rtl/pep_ks_cmd_fifo.sv
// Registered command FIFO for the key-switch scheduler.
//   clk, s_rst : clock, synchronous active-high reset (pointers only)
//   clear      : drop all entries this cycle (wins over push/pop)
//   push       : write push_data (caller guarantees !full)
//   pop        : advance the read pointer (caller guarantees !empty)
//   head       : oldest entry, valid when !empty
//   full/empty : occupancy flags
module pep_ks_cmd_fifo
    import pep_ks_common_param_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = KS_CMD_W
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (s_rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/pep_ks_cmd_sched.sv
// Command scheduler between the PBS sequencer and the key-switch datapath.
// Buffers sequencer commands, turns key-switch enquiry pulses into issue
// credits, issues one command per credit as a 1-cycle avail pulse, caps the
// number of outstanding commands and supports a cache-reset flush.
//   clk, s_rst          : clock, synchronous active-high reset
//   seq_cmd/_vld/_rdy   : command input handshake from the sequencer
//   ks_seq_cmd_enquiry  : key switch can take one more command (+1 credit)
//   seq_ks_cmd/_avail   : issued command and its 1-cycle valid pulse
//   ks_cmd_done         : one issued command has been fully processed
//   reset_cache         : request a flush
//   inflight_cnt        : issued-but-not-done command count
//   sched_error         : [0] credit overflow, [1] done underflow,
//                         [2] push attempted during flush (1-cycle pulses)
module pep_ks_cmd_sched
    import pep_ks_common_param_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int MAX_INFLIGHT   = 2,
    parameter int CREDIT_W       = 4
) (
    input  logic                              clk,
    input  logic                              s_rst,
    input  logic [KS_CMD_W-1:0]               seq_cmd,
    input  logic                              seq_cmd_vld,
    output logic                              seq_cmd_rdy,
    input  logic                              ks_seq_cmd_enquiry,
    output logic [KS_CMD_W-1:0]               seq_ks_cmd,
    output logic                              seq_ks_cmd_avail,
    input  logic                              ks_cmd_done,
    input  logic                              reset_cache,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt,
    output logic [2:0]                        sched_error
);

    localparam int                INFL_W     = $clog2(MAX_INFLIGHT + 1);
    localparam logic [INFL_W-1:0] INFL_MAX   = INFL_W'(MAX_INFLIGHT);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    sched_state_e          state;
    sched_state_e          state_nxt;
    logic [CREDIT_W-1:0]   credit;
    logic [INFL_W-1:0]     inflight;
    sched_error_t          err_nxt;
    sched_error_t          err_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [KS_CMD_W-1:0]   fifo_head;
    logic [KS_CMD_W-1:0]   issue_cmd;
    logic                  push_acc;
    logic                  flush_req;
    logic                  issue;

    // Handshake and issue decision (stage 0, combinational)
    assign seq_cmd_rdy = (state == ST_RUN) && !fifo_full && !s_rst;
    assign push_acc    = seq_cmd_vld && seq_cmd_rdy;
    assign flush_req   = (state == ST_RUN) && reset_cache;

    // A command pushed into an empty FIFO can issue in the same cycle; it
    // goes straight to the issue register and is never written to the FIFO.
    assign issue = (state == ST_RUN) && !reset_cache &&
                   (!fifo_empty || push_acc) &&
                   (credit != '0) && (inflight < INFL_MAX);
    assign issue_cmd = fifo_empty ? seq_cmd : fifo_head;
    assign fifo_pop  = issue && !fifo_empty;
    assign fifo_push = push_acc && !(issue && fifo_empty);

    pep_ks_cmd_fifo #(
        .DEPTH (CMD_FIFO_DEPTH),
        .WIDTH (KS_CMD_W)
    ) u_fifo (
        .clk       (clk),
        .s_rst     (s_rst),
        .clear     (flush_req),
        .push      (fifo_push),
        .push_data (seq_cmd),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (reset_cache)      state_nxt = ST_FLUSH;
            ST_FLUSH: if (inflight == '0)   state_nxt = ST_RUN;
            default:                        state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        err_nxt            = '0;
        err_nxt.credit_ovf = ks_seq_cmd_enquiry && !issue && (credit == CREDIT_MAX);
        err_nxt.done_udf   = ks_cmd_done && !issue && (inflight == '0);
        err_nxt.flush_push = seq_cmd_vld && (state == ST_FLUSH);
    end

    // Control registers (stage 1)
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state    <= ST_RUN;
            credit   <= '0;
            inflight <= '0;
            err_q    <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;

            // Enquiries arriving during the flush are kept as credit.
            if (flush_req)
                credit <= '0;
            else if (ks_seq_cmd_enquiry && !issue && (credit != CREDIT_MAX))
                credit <= credit + 1'b1;
            else if (!ks_seq_cmd_enquiry && issue)
                credit <= credit - 1'b1;

            if (issue && !ks_cmd_done)
                inflight <= inflight + 1'b1;
            else if (ks_cmd_done && !issue && (inflight != '0))
                inflight <= inflight - 1'b1;
        end
    end

    // Issue register (stage 1): command holds its value between pulses
    always_ff @(posedge clk) begin
        if (s_rst) begin
            seq_ks_cmd_avail <= 1'b0;
            seq_ks_cmd       <= '0;
        end else begin
            seq_ks_cmd_avail <= issue;
            if (issue) seq_ks_cmd <= issue_cmd;
        end
    end

    assign inflight_cnt = inflight;
    assign sched_error  = err_q;

endmodule

// File: tb/tb_pep_ks_cmd_sched.sv
module tb_pep_ks_cmd_sched;
    import pep_ks_common_param_pkg::*;

    logic                clk = 1'b0;
    logic                s_rst;
    logic [KS_CMD_W-1:0] seq_cmd;
    logic                seq_cmd_vld;
    logic                seq_cmd_rdy;
    logic                ks_seq_cmd_enquiry;
    logic [KS_CMD_W-1:0] seq_ks_cmd;
    logic                seq_ks_cmd_avail;
    logic                ks_cmd_done;
    logic                reset_cache;
    logic [1:0]          inflight_cnt;
    logic [2:0]          sched_error;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pep_ks_cmd_sched #(
        .CMD_FIFO_DEPTH (4),
        .MAX_INFLIGHT   (2),
        .CREDIT_W       (4)
    ) dut (
        .clk                (clk),
        .s_rst              (s_rst),
        .seq_cmd            (seq_cmd),
        .seq_cmd_vld        (seq_cmd_vld),
        .seq_cmd_rdy        (seq_cmd_rdy),
        .ks_seq_cmd_enquiry (ks_seq_cmd_enquiry),
        .seq_ks_cmd         (seq_ks_cmd),
        .seq_ks_cmd_avail   (seq_ks_cmd_avail),
        .ks_cmd_done        (ks_cmd_done),
        .reset_cache        (reset_cache),
        .inflight_cnt       (inflight_cnt),
        .sched_error        (sched_error)
    );

    // Inputs applied now are consumed at the next rising edge; outputs are
    // sampled 1 time unit after that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        step();
        step();
        n_total++; if (seq_cmd_rdy !== 1'b0) $display("FAIL reset_rdy: got %0b want 0", seq_cmd_rdy); else n_pass++;
        n_total++; if (seq_ks_cmd_avail !== 1'b0) $display("FAIL reset_avail: got %0b want 0", seq_ks_cmd_avail); else n_pass++;
        n_total++; if (seq_ks_cmd !== 8'h00) $display("FAIL reset_cmd: got %h want 00", seq_ks_cmd); else n_pass++;
        n_total++; if (inflight_cnt !== 2'd0) $display("FAIL reset_inflight: got %0d want 0", inflight_cnt); else n_pass++;
        n_total++; if (sched_error !== 3'b000) $display("FAIL reset_err: got %b want 000", sched_error); else n_pass++;
        s_rst = 1'b0;
        #1;
        n_total++; if (seq_cmd_rdy !== 1'b1) $display("FAIL reset_rdy_after: got %0b want 1", seq_cmd_rdy); else n_pass++;
    endtask

    task automatic test_single_issue();
        ks_seq_cmd_enquiry = 1'b1; step();
        ks_seq_cmd_enquiry = 1'b0; step(); step();
        seq_cmd = 8'hA5; seq_cmd_vld = 1'b1; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b1) $display("FAIL single_avail: got %0b want 1", seq_ks_cmd_avail); else n_pass++;
        n_total++; if (seq_ks_cmd !== 8'hA5) $display("FAIL single_cmd: got %h want a5", seq_ks_cmd); else n_pass++;
        n_total++; if (inflight_cnt !== 2'd1) $display("FAIL single_inflight: got %0d want 1", inflight_cnt); else n_pass++;
        seq_cmd_vld = 1'b0; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b0) $display("FAIL single_pulse: got %0b want 0", seq_ks_cmd_avail); else n_pass++;
        n_total++; if (seq_ks_cmd !== 8'hA5) $display("FAIL single_hold: got %h want a5", seq_ks_cmd); else n_pass++;
        ks_cmd_done = 1'b1; step();
        ks_cmd_done = 1'b0;
        n_total++; if (inflight_cnt !== 2'd0) $display("FAIL single_done: got %0d want 0", inflight_cnt); else n_pass++;
        // Credit is now zero: the next command must wait for an enquiry.
        seq_cmd = 8'h11; seq_cmd_vld = 1'b1; step();
        seq_cmd_vld = 1'b0; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b0) $display("FAIL credit_zero_wait: got %0b want 0", seq_ks_cmd_avail); else n_pass++;
        ks_seq_cmd_enquiry = 1'b1; step();
        ks_seq_cmd_enquiry = 1'b0; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h11) $display("FAIL credit_late_issue: got %0b/%h want 1/11", seq_ks_cmd_avail, seq_ks_cmd); else n_pass++;
        ks_cmd_done = 1'b1; step();
        ks_cmd_done = 1'b0;
    endtask

    task automatic test_max_inflight();
        ks_seq_cmd_enquiry = 1'b1; step(); step(); step();
        ks_seq_cmd_enquiry = 1'b0;
        seq_cmd_vld = 1'b1;
        seq_cmd = 8'h21; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h21) $display("FAIL max_issue1: got %0b/%h want 1/21", seq_ks_cmd_avail, seq_ks_cmd); else n_pass++;
        seq_cmd = 8'h22; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h22) $display("FAIL max_issue2: got %0b/%h want 1/22", seq_ks_cmd_avail, seq_ks_cmd); else n_pass++;
        seq_cmd = 8'h23; step();
        seq_cmd_vld = 1'b0;
        n_total++; if (seq_ks_cmd_avail !== 1'b0) $display("FAIL max_block: got %0b want 0", seq_ks_cmd_avail); else n_pass++;
        n_total++; if (inflight_cnt !== 2'd2) $display("FAIL max_inflight: got %0d want 2", inflight_cnt); else n_pass++;
        step(); step();
        n_total++; if (seq_ks_cmd_avail !== 1'b0 || inflight_cnt !== 2'd2) $display("FAIL max_hold: got %0b/%0d want 0/2", seq_ks_cmd_avail, inflight_cnt); else n_pass++;
        ks_cmd_done = 1'b1; step();
        ks_cmd_done = 1'b0;
        n_total++; if (seq_ks_cmd_avail !== 1'b0 || inflight_cnt !== 2'd1) $display("FAIL max_done: got %0b/%0d want 0/1", seq_ks_cmd_avail, inflight_cnt); else n_pass++;
        step();
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h23 || inflight_cnt !== 2'd2) $display("FAIL max_issue3: got %0b/%h/%0d want 1/23/2", seq_ks_cmd_avail, seq_ks_cmd, inflight_cnt); else n_pass++;
        ks_cmd_done = 1'b1; step(); step();
        ks_cmd_done = 1'b0;
        n_total++; if (inflight_cnt !== 2'd0) $display("FAIL max_drain: got %0d want 0", inflight_cnt); else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp_cmd;
        seq_cmd_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seq_cmd = 8'h31 + 8'(i);
            #1;
            n_total++; if (seq_cmd_rdy !== 1'b1) $display("FAIL full_rdy_%0d: got %0b want 1", i, seq_cmd_rdy); else n_pass++;
            step();
        end
        seq_cmd_vld = 1'b0;
        n_total++; if (seq_cmd_rdy !== 1'b0) $display("FAIL full_rdy_low: got %0b want 0", seq_cmd_rdy); else n_pass++;
        ks_seq_cmd_enquiry = 1'b1; step();
        ks_seq_cmd_enquiry = 1'b0;
        n_total++; if (seq_ks_cmd_avail !== 1'b0 || seq_cmd_rdy !== 1'b0) $display("FAIL full_enq: got %0b/%0b want 0/0", seq_ks_cmd_avail, seq_cmd_rdy); else n_pass++;
        step();
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h31) $display("FAIL full_first: got %0b/%h want 1/31", seq_ks_cmd_avail, seq_ks_cmd); else n_pass++;
        n_total++; if (seq_cmd_rdy !== 1'b1) $display("FAIL full_rdy_back: got %0b want 1", seq_cmd_rdy); else n_pass++;
        ks_cmd_done = 1'b1; step();
        ks_cmd_done = 1'b0;
        for (int i = 1; i < 4; i++) begin
            exp_cmd = 8'h31 + 8'(i);
            ks_seq_cmd_enquiry = 1'b1; step();
            ks_seq_cmd_enquiry = 1'b0; step();
            n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== exp_cmd) $display("FAIL full_order_%0d: got %0b/%h want 1/%h", i, seq_ks_cmd_avail, seq_ks_cmd, exp_cmd); else n_pass++;
            ks_cmd_done = 1'b1; step();
            ks_cmd_done = 1'b0;
        end
    endtask

    task automatic test_credit_sat();
        ks_seq_cmd_enquiry = 1'b1; step();
        // Enquiry and issue together: credit stays at 1.
        seq_cmd = 8'h41; seq_cmd_vld = 1'b1; step();
        seq_cmd_vld = 1'b0; ks_seq_cmd_enquiry = 1'b0;
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h41) $display("FAIL sat_same_cycle: got %0b/%h want 1/41", seq_ks_cmd_avail, seq_ks_cmd); else n_pass++;
        ks_cmd_done = 1'b1; step();
        ks_cmd_done = 1'b0;
        seq_cmd = 8'h42; seq_cmd_vld = 1'b1; step();
        seq_cmd_vld = 1'b0;
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h42) $display("FAIL sat_kept_credit: got %0b/%h want 1/42", seq_ks_cmd_avail, seq_ks_cmd); else n_pass++;
        ks_cmd_done = 1'b1; step();
        ks_cmd_done = 1'b0;
        ks_seq_cmd_enquiry = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            n_total++; if (sched_error[0] !== (i == 16)) $display("FAIL sat_err0_%0d: got %0b want %0b", i, sched_error[0], (i == 16)); else n_pass++;
        end
        ks_seq_cmd_enquiry = 1'b0; step();
        n_total++; if (sched_error !== 3'b000) $display("FAIL sat_err_pulse: got %b want 000", sched_error); else n_pass++;
    endtask

    task automatic test_flush();
        seq_cmd_vld = 1'b1;
        seq_cmd = 8'h51; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h51) $display("FAIL flush_issue1: got %0b/%h want 1/51", seq_ks_cmd_avail, seq_ks_cmd); else n_pass++;
        seq_cmd = 8'h52; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h52) $display("FAIL flush_issue2: got %0b/%h want 1/52", seq_ks_cmd_avail, seq_ks_cmd); else n_pass++;
        seq_cmd = 8'h53; step();
        seq_cmd = 8'h54; step();
        seq_cmd_vld = 1'b0;
        reset_cache = 1'b1; step();
        reset_cache = 1'b0;
        n_total++; if (seq_ks_cmd_avail !== 1'b0 || seq_cmd_rdy !== 1'b0) $display("FAIL flush_enter: got %0b/%0b want 0/0", seq_ks_cmd_avail, seq_cmd_rdy); else n_pass++;
        seq_cmd = 8'h77; seq_cmd_vld = 1'b1; step();
        seq_cmd_vld = 1'b0;
        n_total++; if (sched_error !== 3'b100) $display("FAIL flush_push_err: got %b want 100", sched_error); else n_pass++;
        ks_seq_cmd_enquiry = 1'b1; step();
        ks_seq_cmd_enquiry = 1'b0;
        n_total++; if (sched_error !== 3'b000 || seq_cmd_rdy !== 1'b0) $display("FAIL flush_err_clear: got %b/%0b want 000/0", sched_error, seq_cmd_rdy); else n_pass++;
        ks_cmd_done = 1'b1; step();
        n_total++; if (inflight_cnt !== 2'd1 || seq_cmd_rdy !== 1'b0) $display("FAIL flush_done1: got %0d/%0b want 1/0", inflight_cnt, seq_cmd_rdy); else n_pass++;
        step();
        ks_cmd_done = 1'b0;
        n_total++; if (inflight_cnt !== 2'd0 || seq_cmd_rdy !== 1'b0 || seq_ks_cmd_avail !== 1'b0) $display("FAIL flush_done2: got %0d/%0b/%0b want 0/0/0", inflight_cnt, seq_cmd_rdy, seq_ks_cmd_avail); else n_pass++;
        step();
        n_total++; if (seq_cmd_rdy !== 1'b1 || seq_ks_cmd_avail !== 1'b0) $display("FAIL flush_exit: got %0b/%0b want 1/0", seq_cmd_rdy, seq_ks_cmd_avail); else n_pass++;
        // FIFO was dropped; the enquiry seen during the flush issues a new command.
        seq_cmd = 8'h61; seq_cmd_vld = 1'b1; step();
        seq_cmd_vld = 1'b0;
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h61) $display("FAIL flush_after: got %0b/%h want 1/61", seq_ks_cmd_avail, seq_ks_cmd); else n_pass++;
        ks_cmd_done = 1'b1; step();
        ks_cmd_done = 1'b0;
        // reset_cache together with a ready issue: the flush takes priority.
        seq_cmd = 8'h71; seq_cmd_vld = 1'b1; step();
        seq_cmd_vld = 1'b0;
        ks_seq_cmd_enquiry = 1'b1; step();
        ks_seq_cmd_enquiry = 1'b0;
        reset_cache = 1'b1; step();
        reset_cache = 1'b0;
        n_total++; if (seq_ks_cmd_avail !== 1'b0) $display("FAIL flush_wins: got %0b want 0", seq_ks_cmd_avail); else n_pass++;
        step();
        n_total++; if (seq_cmd_rdy !== 1'b1 || seq_ks_cmd_avail !== 1'b0) $display("FAIL flush_short: got %0b/%0b want 1/0", seq_cmd_rdy, seq_ks_cmd_avail); else n_pass++;
        ks_seq_cmd_enquiry = 1'b1; step();
        ks_seq_cmd_enquiry = 1'b0; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b0) $display("FAIL flush_dropped: got %0b want 0", seq_ks_cmd_avail); else n_pass++;
    endtask

    task automatic test_underflow_reset();
        ks_cmd_done = 1'b1; step();
        ks_cmd_done = 1'b0;
        n_total++; if (sched_error !== 3'b010 || inflight_cnt !== 2'd0) $display("FAIL udf_err: got %b/%0d want 010/0", sched_error, inflight_cnt); else n_pass++;
        step();
        n_total++; if (sched_error !== 3'b000) $display("FAIL udf_pulse: got %b want 000", sched_error); else n_pass++;
        seq_cmd = 8'h72; seq_cmd_vld = 1'b1; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b1 || seq_ks_cmd !== 8'h72 || inflight_cnt !== 2'd1) $display("FAIL rst_pre: got %0b/%h/%0d want 1/72/1", seq_ks_cmd_avail, seq_ks_cmd, inflight_cnt); else n_pass++;
        seq_cmd = 8'h73; ks_seq_cmd_enquiry = 1'b1; s_rst = 1'b1; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b0 || seq_ks_cmd !== 8'h00 || inflight_cnt !== 2'd0 || sched_error !== 3'b000 || seq_cmd_rdy !== 1'b0)
            $display("FAIL rst_mid: got avail=%0b cmd=%h infl=%0d err=%b rdy=%0b want 0/00/0/000/0", seq_ks_cmd_avail, seq_ks_cmd, inflight_cnt, sched_error, seq_cmd_rdy);
        else n_pass++;
        s_rst = 1'b0; seq_cmd_vld = 1'b0; ks_seq_cmd_enquiry = 1'b0; step();
        n_total++; if (seq_ks_cmd_avail !== 1'b0 || seq_cmd_rdy !== 1'b1 || inflight_cnt !== 2'd0) $display("FAIL rst_after: got %0b/%0b/%0d want 0/1/0", seq_ks_cmd_avail, seq_cmd_rdy, inflight_cnt); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_rst              = 1'b1;
        seq_cmd            = '0;
        seq_cmd_vld        = 1'b0;
        ks_seq_cmd_enquiry = 1'b0;
        ks_cmd_done        = 1'b0;
        reset_cache        = 1'b0;
        test_reset();
        test_single_issue();
        test_max_inflight();
        test_fifo_full();
        test_credit_sat();
        test_flush();
        test_underflow_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
